// File: rtl/fc_network.sv
// Sequential 3-layer fully connected inference engine: one shared MAC, built-in operands, argmax output.
// Optional macro FC_BIAS_EN adds per-node biases at write-back (b1[j]=1, b2[k]=-k).
module fc_network #(
  parameter int firstLayerNodes  = 3,
  parameter int secondLayerNodes = 2,
  parameter int thirdLayerNodes  = 10,
  parameter int DATA_W           = 8,
  parameter int ACC_W            = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       finished,
  output logic [3:0] result
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_L1     = 3'd1,
    S_L2     = 3'd2,
    S_ARGMAX = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] N1_LAST = 4'(firstLayerNodes - 1);
  localparam logic [3:0] N2_LAST = 4'(secondLayerNodes - 1);
  localparam logic [3:0] N3_LAST = 4'(thirdLayerNodes - 1);

  state_t                   state_q;
  logic [3:0]               i_q, j_q, k_q;
  logic signed [ACC_W-1:0]  acc_q, max_q;
  logic [3:0]               idx_q;
  logic signed [ACC_W-1:0]  h_q [16];
  logic signed [ACC_W-1:0]  o_q [16];
  logic                     finished_q;
  logic [3:0]               result_q;

  logic signed [DATA_W-1:0] w_s, x_s;
  logic signed [ACC_W-1:0]  opnd_s, prod_s, sum_d, wb_d, relu_d, cand_max_d;
  logic [3:0]               cand_idx_d;

  // Operand generation for the shared multiplier: weight on one side, x or h on the other.
  always_comb begin
    w_s    = '0;
    x_s    = DATA_W'(i_q) + DATA_W'(1);
    opnd_s = '0;
    case (state_q)
      S_L1: begin
        w_s    = DATA_W'(i_q) + DATA_W'(j_q) + DATA_W'(1);
        opnd_s = ACC_W'(x_s);
      end
      S_L2: begin
        w_s    = DATA_W'(thirdLayerNodes - 1) - DATA_W'(k_q);
        opnd_s = h_q[j_q];
      end
      default: begin
        w_s    = '0;
        opnd_s = '0;
      end
    endcase
  end

  assign prod_s = ACC_W'(w_s) * opnd_s;
  assign sum_d  = acc_q + prod_s;

`ifdef FC_BIAS_EN
  logic signed [ACC_W-1:0] bias_s;

  // Node bias: +1 for hidden nodes, -k for output nodes.
  always_comb begin
    bias_s = '0;
    if (state_q == S_L1) begin
      bias_s = ACC_W'(1);
    end else begin
      bias_s = ACC_W'(0) - ACC_W'(k_q);
    end
  end

  assign wb_d = sum_d + bias_s;
`else
  assign wb_d = sum_d;
`endif

  assign relu_d = wb_d[ACC_W-1] ? '0 : wb_d;

  // Running argmax: seeded from o[0], later scores win only when strictly greater.
  always_comb begin
    cand_max_d = max_q;
    cand_idx_d = idx_q;
    if (k_q == 4'd0) begin
      cand_max_d = o_q[0];
      cand_idx_d = 4'd0;
    end else if (o_q[k_q] > max_q) begin
      cand_max_d = o_q[k_q];
      cand_idx_d = k_q;
    end else begin
      cand_max_d = max_q;
      cand_idx_d = idx_q;
    end
  end

  // Control FSM together with the accumulator, activation/score storage and outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      i_q        <= 4'd0;
      j_q        <= 4'd0;
      k_q        <= 4'd0;
      acc_q      <= '0;
      max_q      <= '0;
      idx_q      <= 4'd0;
      finished_q <= 1'b0;
      result_q   <= 4'd0;
      for (int n = 0; n < 16; n++) begin
        h_q[n] <= '0;
        o_q[n] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          finished_q <= 1'b0;
          if (enable) begin
            acc_q   <= '0;
            i_q     <= 4'd0;
            j_q     <= 4'd0;
            k_q     <= 4'd0;
            state_q <= S_L1;
          end
        end
        S_L1: begin
          if (i_q == N1_LAST) begin
            h_q[j_q] <= relu_d;
            acc_q    <= '0;
            i_q      <= 4'd0;
            if (j_q == N2_LAST) begin
              j_q     <= 4'd0;
              state_q <= S_L2;
            end else begin
              j_q <= j_q + 4'd1;
            end
          end else begin
            acc_q <= sum_d;
            i_q   <= i_q + 4'd1;
          end
        end
        S_L2: begin
          if (j_q == N2_LAST) begin
            o_q[k_q] <= wb_d;
            acc_q    <= '0;
            j_q      <= 4'd0;
            if (k_q == N3_LAST) begin
              k_q     <= 4'd0;
              state_q <= S_ARGMAX;
            end else begin
              k_q <= k_q + 4'd1;
            end
          end else begin
            acc_q <= sum_d;
            j_q   <= j_q + 4'd1;
          end
        end
        S_ARGMAX: begin
          max_q <= cand_max_d;
          idx_q <= cand_idx_d;
          if (k_q == N3_LAST) begin
            result_q   <= cand_idx_d;
            finished_q <= 1'b1;
            k_q        <= 4'd0;
            state_q    <= S_DONE;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end
        S_DONE: begin
          if (!enable) begin
            finished_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          finished_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign finished = finished_q;
  assign result   = result_q;

endmodule

// File: tb/tb_fc_network.sv
// Directed self-checking bench for fc_network: default build, a small-layer override and a
// narrow-DATA_W instance whose weight wrap makes the winning class non-zero.
module tb_fc_network;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, en0, fin0;
  logic       rst1, en1, fin1;
  logic       rst2, en2, fin2;
  logic [3:0] res0, res1, res2;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

`ifdef FC_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif

  fc_network dut0 (.clk(clk), .reset(rst0), .enable(en0), .finished(fin0), .result(res0));

  fc_network #(.firstLayerNodes(2), .secondLayerNodes(3), .thirdLayerNodes(4))
    dut1 (.clk(clk), .reset(rst1), .enable(en1), .finished(fin1), .result(res1));

  fc_network #(.DATA_W(4))
    dut2 (.clk(clk), .reset(rst2), .enable(en2), .finished(fin2), .result(res2));

  function automatic longint wr(input longint v, input int dw);
    longint m;
    m = v & ((64'sd1 <<< dw) - 64'sd1);
    if (m >= (64'sd1 <<< (dw - 1))) m = m - (64'sd1 <<< dw);
    return m;
  endfunction

  // Reference model of the whole inference, independent of the RTL structure.
  function automatic logic [3:0] model(input int n1, input int n2, input int n3, input int dw, input bit bias);
    longint h[16];
    longint s, best;
    int bi;
    for (int j = 0; j < n2; j++) begin
      s = 0;
      for (int i = 0; i < n1; i++) s += wr(longint'(i + j + 1), dw) * wr(longint'(i + 1), dw);
      if (bias) s += 1;
      h[j] = (s < 0) ? 0 : s;
    end
    best = 0;
    bi = 0;
    for (int k = 0; k < n3; k++) begin
      s = 0;
      for (int j = 0; j < n2; j++) s += wr(longint'(n3 - 1 - k), dw) * h[j];
      if (bias) s -= k;
      if (k == 0 || s > best) begin
        best = s;
        bi = k;
      end
    end
    return 4'(bi);
  endfunction

  function automatic logic fin_of(input int d);
    case (d)
      0: return fin0;
      1: return fin1;
      default: return fin2;
    endcase
  endfunction

  function automatic logic [3:0] res_of(input int d);
    case (d)
      0: return res0;
      1: return res1;
      default: return res2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_wait(input int d, input int start, output int edges);
    edges = start;
    while (fin_of(d) !== 1'b1 && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int e;
    int bad;
    logic [3:0] exp0;
    logic [3:0] popped;

    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    en0 = 1'b0;  en1 = 1'b0;  en2 = 1'b0;
    exp0 = model(3, 2, 10, 8, BIAS);
    repeat (3) tick();
    chk("reset_finished", 32'(fin0), 32'd0);
    chk("reset_result", 32'(res0), 32'd0);
    #2;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    tick();

    exp_q.push_back(exp0);
    en0 = 1'b1;
    run_wait(0, 0, e);
    chk("run1_latency", 32'(e), 32'd37);
    popped = exp_q.pop_front();
    chk("run1_result", 32'(res0), 32'(popped));

    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_finished", 32'(fin0), 32'd1);
      chk("hold_result", 32'(res0), 32'(exp0));
    end
    en0 = 1'b0;
    tick();
    chk("drop_finished", 32'(fin0), 32'd0);
    chk("idle_result_kept", 32'(res0), 32'(exp0));

    exp_q.push_back(exp0);
    en0 = 1'b1;
    run_wait(0, 0, e);
    chk("run2_latency", 32'(e), 32'd37);
    popped = exp_q.pop_front();
    chk("run2_result", 32'(res0), 32'(popped));

    #2 rst0 = 1'b0;
    #1;
    chk("async_reset_done_finished", 32'(fin0), 32'd0);
    en0 = 1'b0;
    tick();
    #2 rst0 = 1'b1;

    en0 = 1'b1;
    repeat (15) tick();
    en0 = 1'b0;
    #3 rst0 = 1'b0;
    #1;
    chk("async_reset_l2_finished", 32'(fin0), 32'd0);
    chk("async_reset_l2_result", 32'(res0), 32'd0);
    #2 rst0 = 1'b1;

    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (fin0 !== 1'b0) bad++;
    end
    chk("idle50_finished_cycles", 32'(bad), 32'd0);

    exp_q.push_back(exp0);
    en0 = 1'b1;
    tick();
    en0 = 1'b0;
    run_wait(0, 1, e);
    chk("pulse_latency", 32'(e), 32'd37);
    popped = exp_q.pop_front();
    chk("pulse_result", 32'(res0), 32'(popped));

    exp_q.push_back(model(2, 3, 4, 8, BIAS));
    en1 = 1'b1;
    run_wait(1, 0, e);
    chk("small_latency", 32'(e), 32'd23);
    popped = exp_q.pop_front();
    chk("small_result", 32'(res_of(1)), 32'(popped));

    exp_q.push_back(model(3, 2, 10, 4, BIAS));
    en2 = 1'b1;
    run_wait(2, 0, e);
    chk("narrow_latency", 32'(e), 32'd37);
    popped = exp_q.pop_front();
    chk("narrow_result", 32'(res_of(2)), 32'(popped));
    #2 rst2 = 1'b0;
    #1;
    chk("narrow_async_reset_result", 32'(res2), 32'd0);
    chk("narrow_async_reset_finished", 32'(fin2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
